// File: rtl/servant_spi_slave_wb.sv
// SPI mode-0 command responder: opcode/address/data frames become byte-wide Wishbone cycles.
// All SPI pins are oversampled in the single system clock domain.
`timescale 1ns/1ps
module servant_spi_slave_wb #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  CMD_WRITE     = 8'h02,
    parameter logic [7:0]  CMD_READ      = 8'h03
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     spi_sck_i,
    input  logic                     spi_cs_i,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
    output logic [31:0]              wb_dat_o,
    output logic [3:0]               wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    input  logic [31:0]              wb_rdt_i,
    input  logic                     wb_ack_i,
    output logic                     overrun_o
);
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StWdata, StRdummy, StRdata, StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0]   sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                     sck_prev_q, cs_prev_q;
    logic                     sck_s, cs_s, mosi_s;
    logic                     sck_rise, sck_fall, cs_rise, cs_fall, byte_done;
    logic [7:0]               byte_in, rd_byte;
    logic [ADDRESS_WIDTH+7:0] addr_cat;
    logic [ADDRESS_WIDTH-1:0] addr_shift;

    state_e                   state_q;
    logic [2:0]               bit_cnt_q;
    logic [6:0]               rx_q;
    logic [1:0]               adr_cnt_q;
    logic                     is_read_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]               pf_q, tx_q;
    logic                     pf_valid_q, miso_q;
    logic [ADDRESS_WIDTH-1:0] wb_adr_q;
    logic [31:0]              wb_dat_q;
    logic [3:0]               wb_sel_q;
    logic                     wb_we_q, wb_cyc_q, overrun_q;

    // CS chain resets low so a CS held low across reset release never looks like a frame start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign cs_rise    = cs_s & ~cs_prev_q;
    assign cs_fall    = ~cs_s & cs_prev_q;
    assign byte_done  = sck_rise & ~cs_s & (bit_cnt_q == 3'd7);
    assign byte_in    = {rx_q, mosi_s};
    assign addr_cat   = {addr_q, byte_in};
    assign addr_shift = addr_cat[ADDRESS_WIDTH-1:0];
    assign rd_byte    = wb_rdt_i[{addr_q[1:0], 3'b000} +: 8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            adr_cnt_q  <= '0;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
            wb_sel_q   <= '0;
            wb_we_q    <= 1'b0;
            wb_cyc_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (sck_rise && !cs_s) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_q      <= byte_in[6:0];
            end
            if (cs_fall) begin
                bit_cnt_q <= '0;
            end
            // The fall right after a load (bit count 0) must keep the freshly presented MSB.
            if (sck_fall && state_q == StRdata && bit_cnt_q != 3'd0) begin
                tx_q   <= {tx_q[6:0], 1'b0};
                miso_q <= tx_q[6];
            end
            if (wb_cyc_q && wb_ack_i) begin
                wb_cyc_q <= 1'b0;
                addr_q   <= addr_q + ADDRESS_WIDTH'(1);
                if (!wb_we_q) begin
                    pf_q       <= rd_byte;
                    pf_valid_q <= 1'b1;
                end
            end

            if (cs_rise) begin
                state_q <= StIdle;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall && !wb_cyc_q) begin
                            state_q    <= StCmd;
                            adr_cnt_q  <= '0;
                            pf_valid_q <= 1'b0;
                        end
                    end
                    StCmd: begin
                        if (byte_done) begin
                            is_read_q <= (byte_in == CMD_READ);
                            state_q   <= (byte_in == CMD_WRITE || byte_in == CMD_READ) ?
                                         StAddr : StIgnore;
                        end
                    end
                    StAddr: begin
                        if (byte_done) begin
                            addr_q    <= addr_shift;
                            adr_cnt_q <= adr_cnt_q + 2'd1;
                            if (adr_cnt_q == 2'd3) begin
                                if (is_read_q) begin
                                    state_q  <= StRdummy;
                                    wb_cyc_q <= 1'b1;
                                    wb_we_q  <= 1'b0;
                                    wb_adr_q <= {addr_shift[ADDRESS_WIDTH-1:2], 2'b00};
                                    wb_sel_q <= 4'b0001 << addr_shift[1:0];
                                end else begin
                                    state_q <= StWdata;
                                end
                            end
                        end
                    end
                    StWdata: begin
                        if (byte_done) begin
                            if (wb_cyc_q) begin
                                overrun_q <= 1'b1;
                            end else begin
                                wb_cyc_q <= 1'b1;
                                wb_we_q  <= 1'b1;
                                wb_adr_q <= {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
                                wb_sel_q <= 4'b0001 << addr_q[1:0];
                                wb_dat_q <= {4{byte_in}};
                            end
                        end
                    end
                    StRdummy, StRdata: begin
                        if (byte_done) begin
                            state_q <= StRdata;
                            if (pf_valid_q) begin
                                tx_q       <= pf_q;
                                miso_q     <= pf_q[7];
                                pf_valid_q <= 1'b0;
                                wb_cyc_q   <= 1'b1;
                                wb_we_q    <= 1'b0;
                                wb_adr_q   <= {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
                                wb_sel_q   <= 4'b0001 << addr_q[1:0];
                            end else begin
                                // Late ack: the pending read refills the prefetch for a later byte.
                                tx_q      <= 8'hFF;
                                miso_q    <= 1'b1;
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                    StIgnore: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign spi_miso_o = miso_q;
    assign wb_adr_o   = wb_adr_q;
    assign wb_dat_o   = wb_dat_q;
    assign wb_sel_o   = wb_sel_q;
    assign wb_we_o    = wb_we_q;
    assign wb_cyc_o   = wb_cyc_q;
    assign overrun_o  = overrun_q;
endmodule

// File: tb/tb_servant_spi_slave_wb.sv
// Bench for servant_spi_slave_wb: SPI master driver, Wishbone memory responder and a
// byte-addressed reference memory that predicts bus traffic and MISO data.
`timescale 1ns/1ps
module tb_servant_spi_slave_wb;
    localparam int H = 6;  // SPI half period in system clocks

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt = '0;
    logic        wb_ack;
    logic        overrun;

    wb_txn_t        obs[$];
    bit [7:0]       bus_mem[bit [31:0]];
    bit [7:0]       ref_mem[bit [31:0]];
    int             ack_delay = 0;
    int             wait_cnt;
    int             ovr_cnt = 0;
    int             miso_hi_cnt = 0;
    int             n_checks = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    servant_spi_slave_wb #(
        .ADDRESS_WIDTH(32),
        .SYNC_STAGES  (2),
        .CMD_WRITE    (8'h02),
        .CMD_READ     (8'h03)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .spi_sck_i (spi_sck),
        .spi_cs_i  (spi_cs),
        .spi_mosi_i(spi_mosi),
        .spi_miso_o(spi_miso),
        .wb_adr_o  (wb_adr),
        .wb_dat_o  (wb_dat),
        .wb_sel_o  (wb_sel),
        .wb_we_o   (wb_we),
        .wb_cyc_o  (wb_cyc),
        .wb_rdt_i  (wb_rdt),
        .wb_ack_i  (wb_ack),
        .overrun_o (overrun)
    );

    function automatic bit [7:0] def_byte(bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic bit [7:0] bus_rd(bit [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return def_byte(a);
    endfunction

    function automatic bit [7:0] ref_rd(bit [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_byte(a);
    endfunction

    function automatic void bus_access(logic we, logic [31:0] adr, logic [3:0] sel,
                                       logic [31:0] dat);
        wb_txn_t t;
        t.we  = we;
        t.adr = adr;
        t.sel = sel;
        t.dat = dat;
        obs.push_back(t);
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) bus_mem[adr + 32'(k)] = dat[8*k +: 8];
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wait_cnt <= 0;
        end else begin
            wb_ack <= 1'b0;
            if (wb_cyc && !wb_ack) begin
                if (wait_cnt >= ack_delay) begin
                    wb_ack   <= 1'b1;
                    wait_cnt <= 0;
                    wb_rdt   <= {bus_rd(wb_adr + 32'd3), bus_rd(wb_adr + 32'd2),
                                 bus_rd(wb_adr + 32'd1), bus_rd(wb_adr)};
                    bus_access(wb_we, wb_adr, wb_sel, wb_dat);
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;
    always @(negedge clk) if (spi_miso) miso_hi_cnt <= miso_hi_cnt + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs_begin();
        spi_cs = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (H) @(negedge clk);
        spi_cs = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            repeat (H) @(negedge clk);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            repeat (H) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_header(input logic [7:0] op, input logic [31:0] a);
        logic [7:0] rx;
        spi_byte(op, 8, rx);
        for (int k = 3; k >= 0; k--) spi_byte(a[8*k +: 8], 8, rx);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (wb_cyc && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bus_idle"}, wb_cyc, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d[$], input int delay);
        logic [7:0]  rx;
        logic [31:0] ea;
        logic [3:0]  se;
        int          base;
        base      = ovr_cnt;
        ack_delay = delay;
        obs.delete();
        cs_begin();
        send_header(8'h02, a);
        foreach (d[i]) spi_byte(d[i], 8, rx);
        cs_end();
        wait_idle("wr");
        check("wr_count", obs.size(), d.size());
        check("wr_overrun", ovr_cnt - base, 0);
        for (int i = 0; i < d.size(); i++) begin
            ea = a + 32'(i);
            se = 4'b0001 << ea[1:0];
            ref_mem[ea] = d[i];
            if (i < obs.size())
                check("wr_txn", {obs[i].we, obs[i].sel, obs[i].adr, obs[i].dat},
                      {1'b1, se, ea[31:2], 2'b00, {4{d[i]}}});
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int n, input int delay);
        logic [7:0]  rx;
        logic [31:0] ea;
        logic [3:0]  se;
        int          base;
        base      = ovr_cnt;
        ack_delay = delay;
        obs.delete();
        cs_begin();
        send_header(8'h03, a);
        spi_byte(8'($urandom), 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'($urandom), 8, rx);
            check("rd_miso_byte", rx, ref_rd(a + 32'(i)));
        end
        cs_end();
        wait_idle("rd");
        check("rd_count_min", obs.size() >= n, 1'b1);
        check("rd_overrun", ovr_cnt - base, 0);
        for (int i = 0; i < n; i++) begin
            ea = a + 32'(i);
            se = 4'b0001 << ea[1:0];
            if (i < obs.size())
                check("rd_txn", {obs[i].we, obs[i].sel, obs[i].adr}, {1'b0, se, ea[31:2], 2'b00});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, spi_miso, 1'b0);
        check({tag, "_cyc"}, wb_cyc, 1'b0);
        check({tag, "_we"}, wb_we, 1'b0);
        check({tag, "_sel"}, wb_sel, 4'h0);
        check({tag, "_adr"}, wb_adr, 32'h0);
        check({tag, "_dat"}, wb_dat, 32'h0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d[$];
        logic [7:0]  rx;
        logic [31:0] a;
        int          base;
        int          n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Two-byte write at 0x10
        d.delete();
        d.push_back(8'hA5);
        d.push_back(8'h5A);
        do_write(32'h10, d, 1);

        // Word 0x44332211 at 0x20, unaligned read of three bytes
        for (int k = 0; k < 4; k++) begin
            bus_mem[32'h20 + 32'(k)] = 8'(8'h11 * (k + 1));
            ref_mem[32'h20 + 32'(k)] = 8'(8'h11 * (k + 1));
        end
        do_read(32'h21, 3, 0);

        // CS rises mid data byte: that byte must not reach the bus
        ack_delay = 0;
        obs.delete();
        cs_begin();
        send_header(8'h02, 32'h40);
        spi_byte(8'h77, 5, rx);
        cs_end();
        wait_idle("abort");
        check("abort_no_write", obs.size(), 0);
        d.delete();
        d.push_back(8'h12);
        do_write(32'h44, d, 0);

        // Unknown opcode: frame ignored
        obs.delete();
        base = miso_hi_cnt;
        cs_begin();
        spi_byte(8'h9F, 8, rx);
        for (int i = 0; i < 8; i++) begin
            spi_byte(8'($urandom), 8, rx);
            check("ignore_miso_byte", rx, 8'h00);
        end
        cs_end();
        wait_idle("ignore");
        check("ignore_no_bus", obs.size(), 0);
        check("ignore_miso_low", miso_hi_cnt - base, 0);

        // Slow ack on a two-byte write: second byte dropped with one overrun pulse
        ack_delay = 20 * 16 * H;
        obs.delete();
        base = ovr_cnt;
        cs_begin();
        send_header(8'h02, 32'h50);
        spi_byte(8'hAA, 8, rx);
        spi_byte(8'hBB, 8, rx);
        cs_end();
        wait_idle("overrun");
        ref_mem[32'h50] = 8'hAA;
        check("overrun_pulses", ovr_cnt - base, 1);
        check("overrun_writes", obs.size(), 1);
        if (obs.size() > 0) check("overrun_first_dat", obs[0].dat, 32'hAAAAAAAA);
        ack_delay = 0;

        // Address counter wrap
        do_read(32'hFFFF_FFFF, 2, 0);

        // Reset asserted mid read
        ack_delay = 0;
        obs.delete();
        cs_begin();
        send_header(8'h03, 32'h20);
        spi_byte(8'h00, 8, rx);
        spi_byte(8'h00, 3, rx);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        spi_cs  = 1'b1;
        spi_sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * H) @(negedge clk);
        do_read(32'h21, 3, 0);

        // Randomised frames over a small window so reads revisit written bytes
        for (int it = 0; it < 12; it++) begin
            a = 32'h100 + 32'($urandom_range(0, 12));
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                d.delete();
                for (int i = 0; i < n; i++) d.push_back(8'($urandom));
                do_write(a, d, $urandom_range(0, 3));
            end else begin
                do_read(a, n, $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
